// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle CPU control unit. Sequences each instruction through
//            FETCH / DECODE / EXEC / MEM / WB, drives the one-hot ALU op bus
//            and the register-file, memory and PC controls, absorbs
//            instruction/data memory stalls and counts retired instructions.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            instr             - instruction word (sampled in FETCH only)
//            imem_ready        - instruction memory data valid
//            dmem_ready        - data memory access completes
//            zero              - ALU result is zero (beq)
//            alu_ctrl[5:0]     - one-hot ALU op {slt,or,and,add,subu,addu}
//            ir_we, pc_we      - IR load / PC write
//            pc_src[1:0]       - 0 PC+4, 1 branch target, 2 jump target
//            reg_we, reg_dst   - register write, rd(1)/rt(0) select
//            alu_src_imm       - ALU operand B from immediate
//            ext_sign          - sign(1)/zero(0) immediate extension
//            mem_rd, mem_we    - data memory read / write request
//            mem_to_reg        - write-back data from memory
//            illegal           - sticky unsupported-opcode flag
//            state[2:0]        - current state (debug)
//            instret[31:0]     - retired-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic [5:0]  alu_ctrl,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        alu_src_imm,
    output logic        ext_sign,
    output logic        mem_rd,
    output logic        mem_we,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;

    localparam logic [5:0] c_ALU_ADDU = 6'b000001;
    localparam logic [5:0] c_ALU_SUBU = 6'b000010;
    localparam logic [5:0] c_ALU_ADD  = 6'b000100;
    localparam logic [5:0] c_ALU_AND  = 6'b001000;
    localparam logic [5:0] c_ALU_OR   = 6'b010000;
    localparam logic [5:0] c_ALU_SLT  = 6'b100000;

    state_t      r_state;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    logic [31:0] r_instret;

    logic        w_is_rtype;
    logic        w_is_ori;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_is_j;
    logic        w_legal;
    logic        w_retire;
    logic [5:0]  w_r_alu;
    logic        w_unused;

    // Only opcode and funct are used here; register/immediate fields go
    // straight to the datapath.
    assign w_unused = ^instr[25:6];

    // Decode is done from the latched fields so that instr may change freely
    // once FETCH has captured it.
    assign w_is_rtype = (r_op == c_OP_RTYPE);
    assign w_is_ori   = (r_op == c_OP_ORI);
    assign w_is_lw    = (r_op == c_OP_LW);
    assign w_is_sw    = (r_op == c_OP_SW);
    assign w_is_beq   = (r_op == c_OP_BEQ);
    assign w_is_j     = (r_op == c_OP_J);

    // R-type funct to one-hot ALU op; zero marks an unsupported funct.
    always_comb begin
        w_r_alu = 6'b000000;
        case (r_funct)
            6'h21:   w_r_alu = c_ALU_ADDU;
            6'h23:   w_r_alu = c_ALU_SUBU;
            6'h20:   w_r_alu = c_ALU_ADD;
            6'h24:   w_r_alu = c_ALU_AND;
            6'h25:   w_r_alu = c_ALU_OR;
            6'h2A:   w_r_alu = c_ALU_SLT;
            default: w_r_alu = 6'b000000;
        endcase
    end

    assign w_legal = (w_is_rtype && (w_r_alu != 6'b000000)) || w_is_ori ||
                     w_is_lw || w_is_sw || w_is_beq || w_is_j;

    // An instruction retires on the edge that leaves its final state.
    assign w_retire = ((r_state == ST_DECODE) && w_is_j)   ||
                      ((r_state == ST_EXEC)   && w_is_beq) ||
                      ((r_state == ST_MEM)    && w_is_sw && dmem_ready) ||
                      (r_state == ST_WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_op      <= 6'h00;
            r_funct   <= 6'h00;
            r_instret <= 32'd0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_op    <= instr[31:26];
                        r_funct <= instr[5:0];
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!w_legal)
                        r_state <= ST_TRAP;
                    else if (w_is_j)
                        r_state <= ST_FETCH;
                    else
                        r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Only legal non-jump instructions reach EXEC, so the
                    // final branch is beq.
                    if (w_is_rtype || w_is_ori)
                        r_state <= ST_WB;
                    else if (w_is_lw || w_is_sw)
                        r_state <= ST_MEM;
                    else
                        r_state <= ST_FETCH;
                end
                ST_MEM: begin
                    if (dmem_ready)
                        r_state <= w_is_lw ? ST_WB : ST_FETCH;
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_FETCH;
            endcase

            if (w_retire)
                r_instret <= r_instret + 32'd1;
        end
    end

    // Output decode from registered state and latched fields; only ir_we and
    // pc_we look at live inputs (imem_ready, zero).
    always_comb begin
        alu_ctrl    = 6'b000000;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        alu_src_imm = 1'b0;
        ext_sign    = 1'b0;
        mem_rd      = 1'b0;
        mem_we      = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                ir_we = imem_ready;
                pc_we = imem_ready;
            end
            ST_DECODE: begin
                if (w_is_j) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                end
            end
            ST_EXEC: begin
                if (w_is_rtype) begin
                    alu_ctrl = w_r_alu;
                end else if (w_is_ori) begin
                    alu_ctrl    = c_ALU_OR;
                    alu_src_imm = 1'b1;
                end else if (w_is_lw || w_is_sw) begin
                    alu_ctrl    = c_ALU_ADDU;
                    alu_src_imm = 1'b1;
                    ext_sign    = 1'b1;
                end else if (w_is_beq) begin
                    alu_ctrl = c_ALU_SUBU;
                    ext_sign = 1'b1;
                    pc_src   = 2'd1;
                    pc_we    = zero;
                end
            end
            ST_MEM: begin
                // Address computation held for the whole access.
                alu_ctrl    = c_ALU_ADDU;
                alu_src_imm = 1'b1;
                ext_sign    = 1'b1;
                mem_rd      = w_is_lw;
                mem_we      = w_is_sw;
            end
            ST_WB: begin
                reg_we     = 1'b1;
                reg_dst    = w_is_rtype;
                mem_to_reg = w_is_lw;
                // Keep the ALU result stable while it is written back.
                if (w_is_rtype) begin
                    alu_ctrl = w_r_alu;
                end else if (w_is_ori) begin
                    alu_ctrl    = c_ALU_OR;
                    alu_src_imm = 1'b1;
                end
            end
            ST_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl: a table of hand-computed
//            vectors, hand-written multi-cycle corner sequences and a long
//            randomized run compared against a phase-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic [5:0]  alu_ctrl;
    logic        ir_we, pc_we, reg_we, reg_dst, alu_src_imm, ext_sign;
    logic        mem_rd, mem_we, mem_to_reg, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] instret;

    mc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .zero        (zero),
        .alu_ctrl    (alu_ctrl),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .alu_src_imm (alu_src_imm),
        .ext_sign    (ext_sign),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_to_reg  (mem_to_reg),
        .illegal     (illegal),
        .state       (state),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // ctl field order: {ir_we, pc_we, pc_src[1:0], reg_we, reg_dst,
    //                   alu_src_imm, ext_sign, mem_rd, mem_we, mem_to_reg, illegal}
    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  alu;
        logic [11:0] ctl;
        logic [31:0] inst;
    } outs_t;

    typedef struct {
        logic [31:0] ins;
        logic        im;
        logic        dm;
        logic        z;
        outs_t       exp;
        bit          care;
    } vec_t;

    localparam logic [31:0] c_ADDU = 32'h0022_1821;
    localparam logic [31:0] c_LW   = 32'h8C22_0004;
    localparam logic [31:0] c_SW   = 32'hAC22_0004;
    localparam logic [31:0] c_BEQ  = 32'h1022_0003;
    localparam logic [31:0] c_ORI  = 32'h3422_00FF;
    localparam logic [31:0] c_SLT  = 32'h0022_182A;
    localparam logic [31:0] c_J    = 32'h0800_0010;
    localparam logic [31:0] c_ILL  = 32'hFC00_0000;
    localparam logic [31:0] c_GARB = 32'hFFFF_FFFF;

    localparam int K_R = 0, K_ORI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Pending phases of the current instruction; empty queue means fetching.
    byte         q[$];
    int          m_cls;
    logic [5:0]  m_fn;
    logic [31:0] m_instret;

    function automatic logic [5:0] r_onehot(input logic [5:0] fn);
        case (fn)
            6'h21:   return 6'b000001;
            6'h23:   return 6'b000010;
            6'h20:   return 6'b000100;
            6'h24:   return 6'b001000;
            6'h25:   return 6'b010000;
            6'h2A:   return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic int classify(input logic [31:0] w);
        case (w[31:26])
            6'h00:   return (r_onehot(w[5:0]) != 6'b0) ? K_R : K_ILL;
            6'h0D:   return K_ORI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic byte cur_phase();
        if (q.size() == 0) return "F";
        return q[0];
    endfunction

    // Expected outputs for the current phase; care=0 leaves the ALU fields
    // unchecked (lw write-back, where the ALU result is not used).
    function automatic outs_t model_exp(input logic im, input logic z, output bit care);
        outs_t o;
        byte   ph;
        o    = '0;
        care = 1'b1;
        ph   = cur_phase();
        o.inst = m_instret;
        case (ph)
            "F": begin o.st = 3'd0; o.ctl[11] = im; o.ctl[10] = im; end
            "D": begin
                o.st = 3'd1;
                if (m_cls == K_J) begin o.ctl[10] = 1'b1; o.ctl[9:8] = 2'd2; end
            end
            "E": begin
                o.st = 3'd2;
                if (m_cls == K_R) o.alu = r_onehot(m_fn);
                if (m_cls == K_ORI) begin o.alu = 6'b010000; o.ctl[5] = 1'b1; end
                if (m_cls == K_LW || m_cls == K_SW) begin
                    o.alu = 6'b000001; o.ctl[5] = 1'b1; o.ctl[4] = 1'b1;
                end
                if (m_cls == K_BEQ) begin
                    o.alu = 6'b000010; o.ctl[4] = 1'b1; o.ctl[9:8] = 2'd1; o.ctl[10] = z;
                end
            end
            "M": begin
                o.st = 3'd3; o.alu = 6'b000001; o.ctl[5] = 1'b1; o.ctl[4] = 1'b1;
                o.ctl[3] = (m_cls == K_LW);
                o.ctl[2] = (m_cls == K_SW);
            end
            "W": begin
                o.st = 3'd4; o.ctl[7] = 1'b1;
                o.ctl[6] = (m_cls == K_R);
                o.ctl[1] = (m_cls == K_LW);
                if (m_cls == K_R) o.alu = r_onehot(m_fn);
                if (m_cls == K_ORI) begin o.alu = 6'b010000; o.ctl[5] = 1'b1; end
                if (m_cls == K_LW) care = 1'b0;
            end
            "T": begin o.st = 3'd7; o.ctl[0] = 1'b1; end
            default: o.st = 3'd0;
        endcase
        return o;
    endfunction

    task automatic model_edge(input logic r, input logic [31:0] ins, input logic im, input logic dm);
        byte ph;
        if (r) begin
            q.delete();
            m_instret = 32'd0;
            return;
        end
        ph = cur_phase();
        if (ph == "F") begin
            if (im) begin
                m_cls = classify(ins);
                m_fn  = ins[5:0];
                case (m_cls)
                    K_J:        q = '{"D"};
                    K_BEQ:      q = '{"D", "E"};
                    K_SW:       q = '{"D", "E", "M"};
                    K_LW:       q = '{"D", "E", "M", "W"};
                    K_ILL:      q = '{"D", "T"};
                    default:    q = '{"D", "E", "W"};
                endcase
            end
        end else if (ph == "T" || (ph == "M" && !dm)) begin
            // stalled or trapped: nothing moves
        end else begin
            void'(q.pop_front());
            if (q.size() == 0) m_instret = m_instret + 32'd1;
        end
    endtask

    // ---------------- checking helpers ----------------
    function automatic outs_t actual();
        outs_t a;
        a.st   = state;
        a.alu  = alu_ctrl;
        a.ctl  = {ir_we, pc_we, pc_src, reg_we, reg_dst, alu_src_imm, ext_sign,
                  mem_rd, mem_we, mem_to_reg, illegal};
        a.inst = instret;
        return a;
    endfunction

    task automatic check(input string nm, input outs_t exp, input bit care);
        outs_t a;
        outs_t m;
        a = actual();
        m = '1;
        if (!care) begin m.alu = '0; m.ctl[5] = 1'b0; m.ctl[4] = 1'b0; end
        n_checks++;
        if ((a & m) === (exp & m))
            n_pass++;
        else
            $display("FAIL %s t=%0t got st=%0d alu=%b ctl=%b instret=%h want st=%0d alu=%b ctl=%b instret=%h",
                     nm, $time, a.st, a.alu, a.ctl, a.inst, exp.st, exp.alu, exp.ctl, exp.inst);
    endtask

    task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", nm, got, want);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cyc(input logic r, input logic [31:0] ins, input logic im,
                       input logic dm, input logic z, input string nm);
        outs_t e;
        bit    c;
        rst = r; instr = ins; imem_ready = im; dmem_ready = dm; zero = z;
        @(negedge clk);
        e = model_exp(im, z, c);
        check(nm, e, c);
        @(posedge clk);
        model_edge(r, ins, im, dm);
        #1;
    endtask

    function automatic vec_t row(input logic [31:0] ins, input logic im, input logic dm,
                                 input logic z, input logic [2:0] st, input logic [5:0] alu,
                                 input logic [11:0] ctl, input logic [31:0] inst, input bit care);
        vec_t v;
        v.ins = ins; v.im = im; v.dm = dm; v.z = z;
        v.exp = {st, alu, ctl, inst};
        v.care = care;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [6];
        logic [31:0] rnd;
        int          sel;
        fns = '{6'h21, 6'h23, 6'h20, 6'h24, 6'h25, 6'h2A};
        rnd = $urandom;
        sel = $urandom_range(11);
        if (sel < 6)   return {6'h00, rnd[25:6], fns[sel]};
        case (sel)
            6:       return {6'h0D, rnd[25:0]};
            7:       return {6'h23, rnd[25:0]};
            8:       return {6'h2B, rnd[25:0]};
            9:       return {6'h04, rnd[25:0]};
            10:      return {6'h02, rnd[25:0]};
            default: return rnd[0] ? {6'h00, rnd[25:6], 6'h00} : {6'h3F, rnd[25:0]};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    vec_t tbl [29];

    initial begin
        // Reset, addu, lw with 3 MEM stalls, beq taken/not taken, ori, slt.
        tbl[0]  = row(c_ADDU, 0, 0, 0, 3'd0, 6'b000000, 12'b0000_0000_0000, 32'd0, 1);
        tbl[1]  = row(c_ADDU, 1, 0, 0, 3'd0, 6'b000000, 12'b1100_0000_0000, 32'd0, 1);
        tbl[2]  = row(c_GARB, 0, 0, 0, 3'd1, 6'b000000, 12'b0000_0000_0000, 32'd0, 1);
        tbl[3]  = row(c_GARB, 1, 0, 0, 3'd2, 6'b000001, 12'b0000_0000_0000, 32'd0, 1);
        tbl[4]  = row(c_GARB, 0, 0, 0, 3'd4, 6'b000001, 12'b0000_1100_0000, 32'd0, 1);
        tbl[5]  = row(c_LW,   0, 0, 0, 3'd0, 6'b000000, 12'b0000_0000_0000, 32'd1, 1);
        tbl[6]  = row(c_LW,   1, 0, 0, 3'd0, 6'b000000, 12'b1100_0000_0000, 32'd1, 1);
        tbl[7]  = row(c_GARB, 0, 0, 0, 3'd1, 6'b000000, 12'b0000_0000_0000, 32'd1, 1);
        tbl[8]  = row(c_GARB, 0, 0, 0, 3'd2, 6'b000001, 12'b0000_0011_0000, 32'd1, 1);
        tbl[9]  = row(c_GARB, 0, 0, 0, 3'd3, 6'b000001, 12'b0000_0011_1000, 32'd1, 1);
        tbl[10] = row(c_GARB, 0, 0, 0, 3'd3, 6'b000001, 12'b0000_0011_1000, 32'd1, 1);
        tbl[11] = row(c_GARB, 0, 0, 0, 3'd3, 6'b000001, 12'b0000_0011_1000, 32'd1, 1);
        tbl[12] = row(c_GARB, 0, 1, 0, 3'd3, 6'b000001, 12'b0000_0011_1000, 32'd1, 1);
        tbl[13] = row(c_GARB, 0, 0, 0, 3'd4, 6'b000000, 12'b0000_1000_0010, 32'd1, 0);
        tbl[14] = row(c_BEQ,  1, 0, 0, 3'd0, 6'b000000, 12'b1100_0000_0000, 32'd2, 1);
        tbl[15] = row(c_GARB, 0, 0, 0, 3'd1, 6'b000000, 12'b0000_0000_0000, 32'd2, 1);
        tbl[16] = row(c_GARB, 0, 0, 1, 3'd2, 6'b000010, 12'b0101_0001_0000, 32'd2, 1);
        tbl[17] = row(c_BEQ,  1, 0, 0, 3'd0, 6'b000000, 12'b1100_0000_0000, 32'd3, 1);
        tbl[18] = row(c_GARB, 0, 0, 0, 3'd1, 6'b000000, 12'b0000_0000_0000, 32'd3, 1);
        tbl[19] = row(c_GARB, 0, 0, 0, 3'd2, 6'b000010, 12'b0001_0001_0000, 32'd3, 1);
        tbl[20] = row(c_ORI,  1, 0, 0, 3'd0, 6'b000000, 12'b1100_0000_0000, 32'd4, 1);
        tbl[21] = row(c_GARB, 0, 0, 1, 3'd1, 6'b000000, 12'b0000_0000_0000, 32'd4, 1);
        tbl[22] = row(c_GARB, 0, 0, 0, 3'd2, 6'b010000, 12'b0000_0010_0000, 32'd4, 1);
        tbl[23] = row(c_GARB, 0, 0, 0, 3'd4, 6'b010000, 12'b0000_1010_0000, 32'd4, 1);
        tbl[24] = row(c_SLT,  1, 0, 0, 3'd0, 6'b000000, 12'b1100_0000_0000, 32'd5, 1);
        tbl[25] = row(c_GARB, 0, 0, 0, 3'd1, 6'b000000, 12'b0000_0000_0000, 32'd5, 1);
        tbl[26] = row(c_GARB, 0, 0, 0, 3'd2, 6'b100000, 12'b0000_0000_0000, 32'd5, 1);
        tbl[27] = row(c_GARB, 0, 0, 0, 3'd4, 6'b100000, 12'b0000_1100_0000, 32'd5, 1);
        tbl[28] = row(c_GARB, 0, 0, 0, 3'd0, 6'b000000, 12'b0000_0000_0000, 32'd6, 1);

        rst = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        m_cls = K_R; m_fn = '0;
        repeat (2) @(posedge clk);
        q.delete();
        m_instret = 32'd0;
        #1;

        for (int i = 0; i < 29; i++) begin
            rst = 1'b0; instr = tbl[i].ins; imem_ready = tbl[i].im;
            dmem_ready = tbl[i].dm; zero = tbl[i].z;
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), tbl[i].exp, tbl[i].care);
            @(posedge clk);
            model_edge(1'b0, tbl[i].ins, tbl[i].im, tbl[i].dm);
            #1;
        end

        // Illegal opcode: trap for 10 cycles, then leave by a 1-cycle reset.
        cyc(0, c_ILL, 1, 0, 0, "ill_fetch");
        cyc(0, c_GARB, 0, 0, 0, "ill_decode");
        for (int i = 0; i < 10; i++) begin
            cyc(0, $urandom, 1, 1, 1, "trap_hold");
            chk_val("trap_state", {29'd0, state}, 32'd7);
        end
        chk_val("trap_illegal", {31'd0, illegal}, 32'd1);
        cyc(1, c_GARB, 1, 1, 1, "trap_rst");
        chk_val("rst_state", {29'd0, state}, 32'd0);
        chk_val("rst_illegal", {31'd0, illegal}, 32'd0);
        chk_val("rst_instret", instret, 32'd0);

        // Counter wrap: preload all-ones, then retire a jump.
        cyc(0, c_J, 1, 0, 0, "j_fetch");
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        m_instret = 32'hFFFF_FFFF;
        chk_val("preload", instret, 32'hFFFF_FFFF);
        cyc(0, c_GARB, 0, 0, 0, "j_decode");
        chk_val("wrap", instret, 32'd0);

        // Reset in the middle of a stalled store.
        cyc(0, c_SW, 1, 0, 0, "sw_fetch");
        cyc(0, c_GARB, 0, 0, 0, "sw_decode");
        cyc(0, c_GARB, 0, 0, 0, "sw_exec");
        cyc(0, c_GARB, 0, 0, 0, "sw_mem_stall");
        chk_val("sw_mem_we", {31'd0, mem_we}, 32'd1);
        cyc(1, c_GARB, 0, 0, 0, "sw_mem_rst");
        chk_val("mem_we_drop", {31'd0, mem_we}, 32'd0);
        chk_val("sw_rst_state", {29'd0, state}, 32'd0);

        // Randomized run against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(49) == 0) || (cur_phase() == "T" && $urandom_range(3) == 0);
            cyc(r, rand_instr(), ($urandom_range(3) != 0), ($urandom_range(2) != 0),
                1'($urandom_range(1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that drives the one-hot `alu_ctrl` bus consumed by the CPU's ALU, plus the register-file, memory and PC controls. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. It handles instruction and data memory stalls through ready inputs and counts retired instructions. It sits between the instruction register and the datapath of the multi-cycle variant of the CPU.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: instruction word from instruction memory; sampled only in FETCH when `imem_ready`=1.
- `imem_ready` in 1: instruction memory data valid this cycle.
- `dmem_ready` in 1: data memory access completes this cycle.
- `zero` in 1: ALU result == 0; used by beq in EXEC.
- `alu_ctrl` out 6: one-hot ALU op. bit0 addu, bit1 subu, bit2 add, bit3 and, bit4 or, bit5 slt; all-zero means idle.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: PC source. 0 is PC+4, 1 is branch target, 2 is jump target.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: write register select. 1 selects rd (R-type), 0 selects rt.
- `alu_src_imm` out 1: ALU operand B is the extended immediate.
- `ext_sign` out 1: immediate extension. 1 is sign-extend, 0 is zero-extend.
- `mem_rd` out 1: data memory read request.
- `mem_we` out 1: data memory write request.
- `mem_to_reg` out 1: write-back data comes from data memory.
- `illegal` out 1: sticky unsupported-opcode flag.
- `state` out 3: current state, for debug.
- `instret` out 32: retired-instruction counter.

## Operation
- Internal registers: `state`, latched `op` (instr[31:26]), latched `funct` (instr[5:0]), `instret`.
- Op and funct are latched only in FETCH when `imem_ready`=1.
- All outputs decode from registered state and latched fields only. There is no combinational path from inputs to outputs, except `pc_we` and `ir_we`, which are gated by `imem_ready` and `zero` as specified below.
- Supported instructions:
  - R-type (op 0x00) with funct 0x21 addu, 0x23 subu, 0x20 add, 0x24 and, 0x25 or, 0x2A slt.
  - ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Anything else is illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - `ir_we` = `pc_we` = `imem_ready`, with `pc_src`=0.
  - If `imem_ready`, go to DECODE; otherwise stay.
- DECODE:
  - Illegal instruction: go to TRAP.
  - j: assert `pc_we` with `pc_src`=2, go to FETCH, retire.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: `alu_ctrl` one-hot per funct; go to WB.
  - ori: `alu_ctrl`=or, `alu_src_imm`=1, `ext_sign`=0; go to WB.
  - lw/sw: `alu_ctrl`=addu, `alu_src_imm`=1, `ext_sign`=1; go to MEM.
  - beq: `alu_ctrl`=subu, `ext_sign`=1, `pc_src`=1, `pc_we`=`zero`; go to FETCH, retire.
- MEM:
  - `alu_ctrl`=addu, `alu_src_imm`=1 and `ext_sign`=1 are held.
  - `mem_rd`=1 for lw; `mem_we`=1 for sw.
  - Stay until `dmem_ready`.
  - Then lw goes to WB; sw goes to FETCH and retires.
- WB:
  - `reg_we`=1.
  - `reg_dst`=1 for R-type, 0 otherwise.
  - `mem_to_reg`=1 for lw.
  - The EXEC `alu_ctrl`, `alu_src_imm` and `ext_sign` values are held for R-type/ori so the ALU result stays stable.
  - Go to FETCH, retire.
- TRAP: `illegal`=1; all enables are 0. Leave only by reset.
- Retire: `instret` increments by 1 on the edge that leaves the retiring state. It wraps from 0xFFFFFFFF to 0.
- `alu_ctrl` is never multi-hot. It is all-zero in FETCH, DECODE and TRAP.

## Timing
- Reset values: `state`=FETCH (0), `instret`=0, `illegal`=0, latched op/funct=0, `alu_ctrl`=0.
  - All enables are 0 after reset, except that `ir_we`/`pc_we` follow `imem_ready` in FETCH.
  - `pc_src`=0; all select outputs are 0.
- Latency with zero wait states:
  - j takes 2 cycles.
  - beq takes 3.
  - sw takes 4.
  - R-type and ori take 4.
  - lw takes 5.
- Each cycle with `imem_ready`=0 or `dmem_ray`=0 adds exactly one cycle. No outputs change during a stall.
- `rst` asserted in any state, including MEM mid-access and TRAP, returns to FETCH on the next edge.
  - `instret` clears even if a retire coincides with that edge.
  - `mem_rd`/`mem_we` drop on the next edge.
- `instr` changing outside FETCH has no effect.

## Test plan
- Reset, then addu (op 0x00, funct 0x21) with no stalls:
  - States go 0,1,2,4,0.
  - `alu_ctrl`=6'b000001 in EXEC and WB.
  - `reg_we`=1, `reg_dst`=1 in WB.
  - `instret`=1 after 4 cycles.
- lw with `dmem_ready` low for 3 MEM cycles:
  - `mem_rd`=1 for 4 cycles, `alu_ctrl`=6'b000001.
  - WB has `mem_to_reg`=1, `reg_dst`=0.
  - Total 8 cycles.
- beq, once with `zero`=1 and once with `zero`=0:
  - EXEC `alu_ctrl`=6'b000010 and `pc_src`=1.
  - `pc_we`=1 only when `zero`=1.
  - Both retire after 3 cycles.
- ori then slt (funct 0x2A):
  - ori: `alu_ctrl`=6'b010000, `ext_sign`=0, `alu_src_imm`=1.
  - slt: `alu_ctrl`=6'b100000.
- Illegal op 0x3F:
  - Enters TRAP (7) with `illegal`=1 and all enables 0 for 10 cycles.
  - `rst` for one cycle returns to FETCH with `illegal`=0.
- Preload `instret` to 0xFFFFFFFF via 2^32 retires (or force), then retire j:
  - `instret`=0.
  - `rst` during a sw MEM stall drops `mem_we` on the next edge.
